// File: rtl/vx_muldiv_commit.sv
// vx_muldiv_commit
//   Consumer side of the MUL/DIV response handshake. Completed responses are
//   buffered in a small FIFO (not fall-through), the head drives the GPR
//   writeback port, and every pop produces a one-cycle retire record carrying
//   the uuid, warp id and active-thread count.
//
// Ports
//   clk, reset         clock, synchronous active-low reset
//   rsp_*              MUL/DIV response (valid/ready + uuid, wid, tmask, PC,
//                      rd, wb, per-lane data; lane i at [32i+31:32i])
//   wb_*               GPR writeback request (valid/ready + wid, tmask, rd,
//                      PC, data); wb_valid never depends on wb_ready
//   cmt_*              retire pulse, uuid, warp id, popcount of tmask
//   pending            number of buffered entries
//
// Optional feature (define MULDIV_COMMIT_PERF_EN)
//   perf_wb_stalls     saturating count of cycles with wb_valid && !wb_ready
//   perf_full_cycles   saturating count of cycles with rsp_valid && !rsp_ready
module vx_muldiv_commit #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int UUID_BITS   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          rsp_valid,
    output logic                          rsp_ready,
    input  logic [UUID_BITS-1:0]          rsp_uuid,
    input  logic [NW_BITS-1:0]            rsp_wid,
    input  logic [NUM_THREADS-1:0]        rsp_tmask,
    input  logic [31:0]                   rsp_PC,
    input  logic [NR_BITS-1:0]            rsp_rd,
    input  logic                          rsp_wb,
    input  logic [NUM_THREADS*32-1:0]     rsp_data,

    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [NW_BITS-1:0]            wb_wid,
    output logic [NUM_THREADS-1:0]        wb_tmask,
    output logic [NR_BITS-1:0]            wb_rd,
    output logic [31:0]                   wb_PC,
    output logic [NUM_THREADS*32-1:0]     wb_data,

    output logic                          cmt_valid,
    output logic [UUID_BITS-1:0]          cmt_uuid,
    output logic [NW_BITS-1:0]            cmt_wid,
    output logic [$clog2(NUM_THREADS):0]  cmt_count,

    output logic [$clog2(FIFO_DEPTH):0]   pending
`ifdef MULDIV_COMMIT_PERF_EN
    ,
    output logic [31:0]                   perf_wb_stalls,
    output logic [31:0]                   perf_full_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(NUM_THREADS) + 1;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

    // Response storage, one array per field.
    logic [UUID_BITS-1:0]      mem_uuid  [FIFO_DEPTH];
    logic [NW_BITS-1:0]        mem_wid   [FIFO_DEPTH];
    logic [NUM_THREADS-1:0]    mem_tmask [FIFO_DEPTH];
    logic [31:0]               mem_pc    [FIFO_DEPTH];
    logic [NR_BITS-1:0]        mem_rd    [FIFO_DEPTH];
    logic                      mem_wb    [FIFO_DEPTH];
    logic [NUM_THREADS*32-1:0] mem_data  [FIFO_DEPTH];

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;

    logic             not_empty;
    logic             head_write;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] head_count;

    // The head entry is never overwritten while buffered, so driving wb_*
    // straight from storage keeps them stable across a stall.
    assign not_empty  = (pending != '0);
    assign head_write = not_empty && mem_wb[rptr] && (mem_tmask[rptr] != '0);

    assign rsp_ready  = (pending != FULL_LVL);
    assign push       = rsp_valid && rsp_ready;
    // Entries with nothing to write retire without waiting for the port.
    assign pop        = not_empty && (!head_write || wb_ready);

    assign wb_valid   = head_write;
    assign wb_wid     = mem_wid[rptr];
    assign wb_tmask   = mem_tmask[rptr];
    assign wb_rd      = mem_rd[rptr];
    assign wb_PC      = mem_pc[rptr];
    assign wb_data    = mem_data[rptr];

    always_comb begin
        head_count = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            head_count = head_count + CNT_W'(mem_tmask[rptr][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_uuid[wptr]  <= rsp_uuid;
            mem_wid[wptr]   <= rsp_wid;
            mem_tmask[wptr] <= rsp_tmask;
            mem_pc[wptr]    <= rsp_PC;
            mem_rd[wptr]    <= rsp_rd;
            mem_wb[wptr]    <= rsp_wb;
            mem_data[wptr]  <= rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr      <= '0;
            wptr      <= '0;
            pending   <= '0;
            cmt_valid <= 1'b0;
            cmt_uuid  <= '0;
            cmt_wid   <= '0;
            cmt_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   pending <= pending + (PTR_W + 1)'(1);
                2'b01:   pending <= pending - (PTR_W + 1)'(1);
                default: pending <= pending;
            endcase
            cmt_valid <= pop;
            if (pop) begin
                cmt_uuid  <= mem_uuid[rptr];
                cmt_wid   <= mem_wid[rptr];
                cmt_count <= head_count;
            end
        end
    end

`ifdef MULDIV_COMMIT_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_wb_stalls   <= '0;
            perf_full_cycles <= '0;
        end else begin
            if (wb_valid && !wb_ready && (perf_wb_stalls != '1)) begin
                perf_wb_stalls <= perf_wb_stalls + 32'd1;
            end
            if (rsp_valid && !rsp_ready && (perf_full_cycles != '1)) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_muldiv_commit.sv
module tb_vx_muldiv_commit;

    localparam int NT    = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_uuid;
    logic [1:0]   rsp_wid;
    logic [3:0]   rsp_tmask;
    logic [31:0]  rsp_PC;
    logic [4:0]   rsp_rd;
    logic         rsp_wb;
    logic [127:0] rsp_data;
    logic         wb_valid;
    logic         wb_ready;
    logic [1:0]   wb_wid;
    logic [3:0]   wb_tmask;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_PC;
    logic [127:0] wb_data;
    logic         cmt_valid;
    logic [15:0]  cmt_uuid;
    logic [1:0]   cmt_wid;
    logic [2:0]   cmt_count;
    logic [2:0]   pending;
`ifdef MULDIV_COMMIT_PERF_EN
    logic [31:0]  perf_wb_stalls;
    logic [31:0]  perf_full_cycles;
`endif

    vx_muldiv_commit #(
        .NUM_THREADS(NT),
        .NW_BITS(2),
        .NR_BITS(5),
        .UUID_BITS(16),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid),
        .rsp_tmask(rsp_tmask),
        .rsp_PC(rsp_PC),
        .rsp_rd(rsp_rd),
        .rsp_wb(rsp_wb),
        .rsp_data(rsp_data),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_wid(wb_wid),
        .wb_tmask(wb_tmask),
        .wb_rd(wb_rd),
        .wb_PC(wb_PC),
        .wb_data(wb_data),
        .cmt_valid(cmt_valid),
        .cmt_uuid(cmt_uuid),
        .cmt_wid(cmt_wid),
        .cmt_count(cmt_count),
        .pending(pending)
`ifdef MULDIV_COMMIT_PERF_EN
        ,
        .perf_wb_stalls(perf_wb_stalls),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [15:0]  uuid;
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic         wb;
        logic [127:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_cmt_valid = 1'b0;
    logic [15:0] m_cmt_uuid  = '0;
    logic [1:0]  m_cmt_wid   = '0;
    logic [2:0]  m_cmt_count = '0;
    int unsigned m_stalls    = 0;
    int unsigned m_full      = 0;

    // Compares the outputs of the state reached at the last rising edge, then
    // advances the model to the state the coming rising edge produces.
    always @(negedge clk) begin
        if (started) begin
            ent_t h;
            bit   m_write;
            bit   m_pop;
            bit   m_push;
            int   sz;
            sz      = q.size();
            if (sz > 0) h = q[0];
            m_write = (sz > 0) && h.wb && (h.tmask != 4'b0);

            check("pending",   128'(pending),   128'(sz));
            check("rsp_ready", 128'(rsp_ready), 128'(sz != DEPTH));
            check("wb_valid",  128'(wb_valid),  128'(m_write));
            if (m_write) begin
                check("wb_wid",   128'(wb_wid),   128'(h.wid));
                check("wb_tmask", 128'(wb_tmask), 128'(h.tmask));
                check("wb_rd",    128'(wb_rd),    128'(h.rd));
                check("wb_PC",    128'(wb_PC),    128'(h.pc));
                check("wb_data",  wb_data,        h.data);
            end
            check("cmt_valid", 128'(cmt_valid), 128'(m_cmt_valid));
            if (m_cmt_valid) begin
                check("cmt_uuid",  128'(cmt_uuid),  128'(m_cmt_uuid));
                check("cmt_wid",   128'(cmt_wid),   128'(m_cmt_wid));
                check("cmt_count", 128'(cmt_count), 128'(m_cmt_count));
            end
`ifdef MULDIV_COMMIT_PERF_EN
            check("perf_wb_stalls",   128'(perf_wb_stalls),   128'(m_stalls));
            check("perf_full_cycles", 128'(perf_full_cycles), 128'(m_full));
`endif

            if (!reset) begin
                q.delete();
                m_cmt_valid = 1'b0;
                m_stalls    = 0;
                m_full      = 0;
            end else begin
                m_pop  = (sz > 0) && (!m_write || wb_ready);
                m_push = rsp_valid && (sz != DEPTH);
                if (m_write && !wb_ready && m_stalls != 32'hFFFF_FFFF) m_stalls++;
                if (rsp_valid && sz == DEPTH && m_full != 32'hFFFF_FFFF) m_full++;
                m_cmt_valid = m_pop;
                if (m_pop) begin
                    m_cmt_uuid  = h.uuid;
                    m_cmt_wid   = h.wid;
                    m_cmt_count = 3'($countones(h.tmask));
                    void'(q.pop_front());
                end
                if (m_push) begin
                    ent_t e;
                    e.uuid  = rsp_uuid;
                    e.wid   = rsp_wid;
                    e.tmask = rsp_tmask;
                    e.pc    = rsp_PC;
                    e.rd    = rsp_rd;
                    e.wb    = rsp_wb;
                    e.data  = rsp_data;
                    q.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_rsp(input logic [15:0] uuid, input logic [1:0] wid, input logic [3:0] tmask,
                           input logic [4:0] rd, input logic wb, input logic [127:0] data);
        rsp_valid = 1'b1;
        rsp_uuid  = uuid;
        rsp_wid   = wid;
        rsp_tmask = tmask;
        rsp_PC    = 32'h1000 + 32'(uuid) * 4;
        rsp_rd    = rd;
        rsp_wb    = wb;
        rsp_data  = data;
    endtask

    // One clock; a response offered while rsp_ready is high is withdrawn
    // once the edge has taken it.
    task automatic tick();
        logic acc;
        acc = rsp_valid && rsp_ready;
        @(posedge clk);
        #2;
        if (acc) rsp_valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d0;
        int n;
        reset     = 1'b0;
        rsp_valid = 1'b0;
        wb_ready  = 1'b1;
        set_rsp(16'h0, 2'd0, 4'h0, 5'd0, 1'b0, '0);
        rsp_valid = 1'b0;

        @(posedge clk);
        #2;
        started = 1'b1;
        tick();

        // Reset state
        check("rst_pending",   128'(pending),   128'(0));
        check("rst_wb_valid",  128'(wb_valid),  128'(0));
        check("rst_cmt_valid", 128'(cmt_valid), 128'(0));
        check("rst_cmt_uuid",  128'(cmt_uuid),  128'(0));
        check("rst_cmt_wid",   128'(cmt_wid),   128'(0));
        check("rst_cmt_count", 128'(cmt_count), 128'(0));
        check("rst_rsp_ready", 128'(rsp_ready), 128'(1));

        // Single writeback
        reset = 1'b1;
        d0 = {32'h44, 32'h33, 32'h22, 32'h11};
        set_rsp(16'h0055, 2'd1, 4'b1011, 5'd7, 1'b1, d0);
        tick();
        check("t1_wb_valid",  128'(wb_valid),  128'(1));
        check("t1_wb_rd",     128'(wb_rd),     128'(7));
        check("t1_wb_tmask",  128'(wb_tmask),  128'(4'b1011));
        check("t1_wb_data",   wb_data,         d0);
        check("t1_cmt_early", 128'(cmt_valid), 128'(0));
        tick();
        check("t1_cmt_valid", 128'(cmt_valid), 128'(1));
        check("t1_cmt_wid",   128'(cmt_wid),   128'(1));
        check("t1_cmt_count", 128'(cmt_count), 128'(3));
        check("t1_cmt_uuid",  128'(cmt_uuid),  128'(16'h0055));
        tick();
        check("t1_cmt_once",  128'(cmt_valid), 128'(0));

        // Fill while the port is stalled, then drain in order
        wb_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (!rsp_valid && n < 5) begin
                set_rsp(16'(n), 2'(n), 4'hF, 5'(n + 1), 1'b1, rnd_data());
                n++;
            end
            tick();
        end
        check("t2_pending_full", 128'(pending),   128'(4));
        check("t2_ready_low",    128'(rsp_ready), 128'(0));
        wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_wb_no_gap", 128'(wb_valid), 128'(1));
            tick();
            check("t2_cmt_valid", 128'(cmt_valid), 128'(1));
            check("t2_cmt_order", 128'(cmt_uuid),  128'(i));
        end
        check("t2_drained", 128'(pending), 128'(0));

        // Entries with nothing to write
        set_rsp(16'd10, 2'd2, 4'hF, 5'd3, 1'b0, rnd_data());
        tick();
        check("t3_skip_a_wb", 128'(wb_valid), 128'(0));
        set_rsp(16'd11, 2'd3, 4'h0, 5'd4, 1'b1, rnd_data());
        tick();
        check("t3_skip_b_wb", 128'(wb_valid),  128'(0));
        check("t3_cmt_a",     128'(cmt_valid), 128'(1));
        check("t3_cnt_a",     128'(cmt_count), 128'(4));
        tick();
        check("t3_cmt_b",     128'(cmt_valid), 128'(1));
        check("t3_cnt_b",     128'(cmt_count), 128'(0));
        check("t3_uuid_b",    128'(cmt_uuid),  128'(11));
        tick();
        check("t3_cmt_end",   128'(cmt_valid), 128'(0));

        // Continuous stream at full rate
        for (int k = 0; k < 12; k++) begin
            set_rsp(16'(100 + k), 2'(k), 4'(k % 15 + 1), 5'(k), 1'b1, rnd_data());
            tick();
            check("t4_pending_one", 128'(pending), 128'(1));
            if (k >= 1) check("t4_cmt_every", 128'(cmt_valid), 128'(1));
        end
        tick();
        tick();
        check("t4_drained", 128'(pending), 128'(0));

        // Stall with valid head, then reset in the middle of it
        wb_ready = 1'b0;
        d0 = rnd_data();
        set_rsp(16'd200, 2'd2, 4'b0110, 5'd9, 1'b1, d0);
        tick();
        set_rsp(16'd201, 2'd1, 4'hF, 5'd10, 1'b1, rnd_data());
        tick();
        for (int s = 0; s < 3; s++) begin
            check("t5_stall_valid", 128'(wb_valid), 128'(1));
            check("t5_stall_rd",    128'(wb_rd),    128'(9));
            check("t5_stall_wid",   128'(wb_wid),   128'(2));
            check("t5_stall_tmask", 128'(wb_tmask), 128'(4'b0110));
            check("t5_stall_data",  wb_data,        d0);
            tick();
        end
        reset = 1'b0;
        tick();
        check("t5_rst_pending", 128'(pending),   128'(0));
        check("t5_rst_wb",      128'(wb_valid),  128'(0));
        check("t5_rst_cmt",     128'(cmt_valid), 128'(0));
        reset    = 1'b1;
        wb_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t5_no_cmt", 128'(cmt_valid), 128'(0));
        end

`ifdef MULDIV_COMMIT_PERF_EN
        // Counters start from the reset above; traffic has been idle since.
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_rsp(16'(300 + k), 2'd0, 4'hF, 5'd1, 1'b1, rnd_data());
            tick();
        end
        check("p_stalls_fill", 128'(perf_wb_stalls),   128'(3));
        check("p_full_fill",   128'(perf_full_cycles), 128'(0));
        set_rsp(16'd304, 2'd0, 4'hF, 5'd1, 1'b1, rnd_data());
        wb_ready = 1'b1;
        tick();
        check("p_stalls_a", 128'(perf_wb_stalls),   128'(3));
        check("p_full_a",   128'(perf_full_cycles), 128'(1));
        wb_ready = 1'b0;
        tick();
        set_rsp(16'd305, 2'd0, 4'hF, 5'd1, 1'b1, rnd_data());
        tick();
        check("p_stalls_b", 128'(perf_wb_stalls),   128'(5));
        check("p_full_b",   128'(perf_full_cycles), 128'(2));
        wb_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (!rsp_valid && $urandom_range(0, 9) < 7) begin
                set_rsp(16'($urandom), 2'($urandom), 4'($urandom), 5'($urandom),
                        ($urandom_range(0, 9) < 8), rnd_data());
            end
            wb_ready = ($urandom_range(0, 9) < 7);
            reset    = ($urandom_range(0, 299) != 0);
            tick();
        end

        reset     = 1'b1;
        wb_ready  = 1'b1;
        rsp_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("end_drained", 128'(pending), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vx_muldiv_commit.md
Name: vx_muldiv_commit

Overview:
- Consumer side of the MUL/DIV unit response handshake (valid/ready with uuid, wid, tmask, PC, rd, wb, data).
- Buffers completed responses in a small FIFO and drives the GPR writeback port one response per cycle.
- Emits a one-cycle retire record per response, with per-warp thread count, for the commit and perf logic.
- Decouples MUL/DIV back-pressure from writeback-port arbitration stalls.

Parameters:
NUM_THREADS, 4, lanes per warp
NW_BITS, 2, warp id width
NR_BITS, 5, register index width
UUID_BITS, 16, instruction uuid width
FIFO_DEPTH, 4, response buffer entries; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
rsp_valid  in  1  response from MUL/DIV valid
rsp_ready  out  1  block can accept response
rsp_uuid  in  UUID_BITS  instruction uuid
rsp_wid  in  NW_BITS  warp id
rsp_tmask  in  NUM_THREADS  active thread mask
rsp_PC  in  32  instruction PC
rsp_rd  in  NR_BITS  destination register
rsp_wb  in  1  writeback required
rsp_data  in  NUM_THREADS*32  per-lane result, lane i at [32i+31:32i]
wb_valid  out  1  writeback request
wb_ready  in  1  GPR write port accepts
wb_wid  out  NW_BITS  warp id
wb_tmask  out  NUM_THREADS  lane write enables
wb_rd  out  NR_BITS  destination register
wb_PC  out  32  PC (debug)
wb_data  out  NUM_THREADS*32  lane data
cmt_valid  out  1  retire pulse
cmt_uuid  out  UUID_BITS  retired uuid
cmt_wid  out  NW_BITS  retired warp
cmt_count  out  $clog2(NUM_THREADS)+1  popcount of retired tmask
pending  out  $clog2(FIFO_DEPTH)+1  entries currently buffered

Behaviour:
- Reset (reset==0 at a clk edge): FIFO empty, read/write pointers 0, pending=0, cmt_valid=0, cmt_* =0, wb_valid=0. rsp_ready=1 on the first cycle after reset deasserts. Reset mid-operation discards all buffered entries; no cmt pulse is generated for them.
- Push: when rsp_valid && rsp_ready, store {uuid,wid,tmask,PC,rd,wb,data} at wptr; wptr wraps modulo FIFO_DEPTH.
- rsp_ready = (pending != FIFO_DEPTH). There is no full-bypass: when full, rsp_ready stays 0 even if a pop occurs the same cycle.
- FIFO is not fall-through. A response accepted in cycle N appears at the head no earlier than cycle N+1.
- Head classification, when pending>0:
  - WRITE: head.wb==1 && head.tmask!=0. wb_valid=1 with wb_* driven from the head, registered outputs or direct from storage; stable while stalled. Pop when wb_valid && wb_ready.
  - SKIP: otherwise. wb_valid=0; head pops unconditionally that cycle.
- At most one pop per cycle.
- Retire: every pop registers cmt_valid=1 on the next cycle, with cmt_uuid/cmt_wid from the popped entry and cmt_count=popcount(tmask). cmt_valid is 0 in any cycle not following a pop. Back-to-back pops give consecutive cmt pulses.
- pending: increments on push-only, decrements on pop-only, unchanged on simultaneous push and pop. Simultaneous push and pop on an empty FIFO is impossible because no head exists.
- Ordering: strict FIFO. Writeback and retire order equal acceptance order.
- wb_valid must never depend combinationally on wb_ready. wb_* must not change while wb_valid && !wb_ready.
- Steady-state throughput: 1 response/cycle with wb_ready held 1.

Optional Feature:
- Macro: MULDIV_COMMIT_PERF_EN.
- Defined:
  - Adds output perf_wb_stalls (32): counts cycles with wb_valid && !wb_ready.
  - Adds output perf_full_cycles (32): counts cycles with rsp_valid && !rsp_ready.
  - Both counters clear on reset and saturate at 0xFFFFFFFF.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then a single push {wid=1, tmask=4'b1011, rd=7, wb=1, data lanes=0x11,0x22,0x33,0x44} with wb_ready=1:
  - wb_valid=1 exactly one cycle after accept, wb_rd=7, wb_tmask=1011.
  - cmt_valid pulses the cycle after that with cmt_wid=1, cmt_count=3.
- wb_ready=0 while pushing 5 responses (FIFO_DEPTH=4):
  - rsp_ready drops after 4 accepts, pending=4, 5th held.
  - Raise wb_ready: 5 writebacks in uuid order 0..4 with no gaps after the 5th enters.
- Push a response with wb=0 and one with tmask=0:
  - No wb_valid for either.
  - Two cmt pulses on consecutive cycles, cmt_count=4 then 0.
- Continuous rsp_valid with wb_ready=1:
  - One accept per cycle; pending stays at 1 in steady state.
  - cmt_valid high every cycle after the 2-cycle startup.
- Stall mid-burst: wb_ready=0 for 3 cycles with the head valid:
  - wb_* constant during the stall.
  - Assert reset==0 during the stall: pending=0, wb_valid=0, no cmt pulses afterwards for the discarded entries.
- With MULDIV_COMMIT_PERF_EN: 3 stall cycles and 2 full-blocked cycles give perf_wb_stalls=3 and perf_full_cycles=2.
